seven_seg_scan_driver: RTL and testbench
========================================

Name: seven_seg_scan_driver

Overview:
- Downstream consumer of the stopwatch digit bus (in0..in5, each {dp, hex[3:0]}).
- Time-multiplexes the six digits onto one common-anode seven-segment display: one shared segment bus plus six digit enables, all active-low.
- Inserts a blanking gap between digits to suppress ghosting.
- Takes a frame-coherent snapshot of all six inputs once per scan frame, so a carry ripple never shows as a torn reading.

Parameters:
REFRESH_DIV, 50_000, clock cycles per digit slot (1 kHz slot rate at 50 MHz, ~167 Hz frame); legal range ≥ 2
BLANK_CYCLES, 500, cycles at the start of each slot with all digits off; legal range 1 ≤ BLANK_CYCLES < REFRESH_DIV

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in0  input  5  digit 0 (rightmost): bit4 = decimal point on, bits3:0 = hex value
in1  input  5  digit 1, same format
in2  input  5  digit 2, same format
in3  input  5  digit 3, same format
in4  input  5  digit 4, same format
in5  input  5  digit 5 (leftmost), same format
seg_out  output  8  {dp,g,f,e,d,c,b,a}, active-low
sel_out  output  6  digit enables, bit k drives digit k, active-low

Behaviour:
- Reset is asynchronous and active-low, on rst_n. While asserted, or when asserted mid-scan, the following apply immediately:
  - cnt = 0, idx = 0.
  - All six snapshot registers = 5'h00.
  - seg_out = 8'hFF, sel_out = 6'b111111 (display dark).
- State: slot counter cnt (0..REFRESH_DIV-1), digit index idx (0..5), six 5-bit snapshot registers snap0..snap5.
- cnt increments every clock. At REFRESH_DIV-1 it wraps to 0 and idx advances. idx wraps from 5 to 0. No other stall or enable exists.
- Phase within a slot:
  - BLANK when cnt < BLANK_CYCLES.
  - LIT when cnt ≥ BLANK_CYCLES.
- Snapshot: on the clock edge that ends the cycle with idx==0 and cnt==BLANK_CYCLES-1, all six inputs are loaded into snap0..snap5 together.
  - Inputs are otherwise ignored.
  - Input changes mid-frame appear only at the next frame's snapshot.
  - The first snapshot after reset occurs in the first slot, before any digit lights.
- Outputs are registered: seg_out and sel_out in cycle n+1 reflect (idx, cnt, snap) in cycle n.
- Output in BLANK phase: sel_out = 6'b111111, seg_out = 8'hFF.
- Output in LIT phase:
  - sel_out = all ones except bit idx = 0.
  - seg_out[6:0] = decode(snap_idx[3:0]).
  - seg_out[7] = ~snap_idx[4].
- Decode table, active-low {g..a}, hex:
  - 0:40  1:79  2:24  3:30
  - 4:19  5:12  6:02  7:78
  - 8:00  9:10  A:08  b:03
  - C:46  d:21  E:06  F:0E
  - All 16 codes are defined; there are no don't-cares.
- Invariants:
  - At most one sel_out bit is low in any cycle.
  - sel_out is never low in two consecutive slots without ≥ BLANK_CYCLES cycles of all-high between them.
- Width rules:
  - cnt is sized to clog2(REFRESH_DIV).
  - The wrap compare is exact equality to REFRESH_DIV-1; there is no overflow reliance.
- Illegal parameters (BLANK_CYCLES=0 or BLANK_CYCLES ≥ REFRESH_DIV) fail elaboration via a generate-time check.

Test Plan:
1. Reset release check, REFRESH_DIV=8, BLANK_CYCLES=2.
   - Stimulus: hold rst_n low 3 cycles, then release.
   - Required: during reset, sel_out=3F and seg_out=FF. After release, sel_out stays 3F for 3 cycles (2 blank + 1 register latency), then 3E for 6 cycles, then 3F for 2 cycles, then 3D.
2. Decode check.
   - Stimulus: in0..in5 = 00,01,02,03,04,05, static.
   - Required: during each digit's lit window, seg_out = C0,F9,A4,B0,99,92. Step through all hex values 0..F on in0 and check against the table over 16 frames.
3. Decimal point.
   - Stimulus: in1=5'h15, in3=5'h10.
   - Required: seg_out = 12 in digit 1's lit window and 40 in digit 3's; other digits show dp bit = 1.
4. Frame coherence.
   - Stimulus: change in0..in5 from 09,19,05,10,00,00 to 00,10,00,11,00,00 while idx=2 is lit.
   - Required: the remainder of the frame still shows the old values; the next frame shows the new ones in all digits.
5. Mid-scan reset.
   - Stimulus: assert rst_n low while idx=4 is lit.
   - Required: the same cycle (asynchronous) gives sel_out=3F and seg_out=FF. After release, scanning restarts at digit 0 with a fresh snapshot.
6. Long run, default parameters, 50 MHz.
   - Stimulus: run ≥ 2 frames.
   - Required: digit period = 300_000 cycles, each lit window = 49_500 cycles, and no cycle has more than one sel_out bit low.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed driver for a six-digit common-anode seven-segment display.
// The six digits are snapshotted once per frame, and each digit slot opens with a blanking gap.
module seven_seg_scan_driver #(
    parameter int REFRESH_DIV  = 50_000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] in0,
    input  logic [4:0] in1,
    input  logic [4:0] in2,
    input  logic [4:0] in3,
    input  logic [4:0] in4,
    input  logic [4:0] in5,
    output logic [7:0] seg_out,
    output logic [5:0] sel_out
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LEN = CNT_W'(BLANK_CYCLES);
    localparam logic [CNT_W-1:0] SNAP_CNT  = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [2:0]       IDX_LAST  = 3'd5;

    if (REFRESH_DIV < 2 || BLANK_CYCLES < 1 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_params
        $error("seven_seg_scan_driver: need REFRESH_DIV >= 2 and 1 <= BLANK_CYCLES < REFRESH_DIV");
    end

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [5:0][4:0]  snap;
    logic             snap_en;
    logic [4:0]       cur;
    logic [7:0]       seg_nxt;
    logic [5:0]       sel_nxt;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex value.
    function automatic logic [6:0] decode(input logic [3:0] hex);
        case (hex)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            4'hF: decode = 7'h0E;
        endcase
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Load the snapshot just before digit 0 lights, so one frame always shows one coherent reading.
    assign snap_en = (idx == 3'd0) && (cnt == SNAP_CNT);

    // NOTE: the snapshot registers are reset too, so the first frame after reset never shows X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap <= '0;
        end else if (snap_en) begin
            snap <= {in5, in4, in3, in2, in1, in0};
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        cur     = snap[idx];
        sel_nxt = 6'h3F;
        seg_nxt = 8'hFF;
        if (cnt >= BLANK_LEN) begin
            sel_nxt = ~(6'b00_0001 << idx);
            seg_nxt = {~cur[4], decode(cur[3:0])};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out <= 8'hFF;
            sel_out <= 6'h3F;
        end else begin
            seg_out <= seg_nxt;
            sel_out <= sel_nxt;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: a cycle scoreboard plus vector tables, with hand-written
// sequences for reset release, frame coherence, mid-scan reset and slot timing.
module tb_seven_seg_scan_driver;

    localparam int RD    = 8;
    localparam int BL    = 2;
    localparam int FRAME = 6 * RD;
    localparam int RD_B  = 100;
    localparam int BL_B  = 10;

    typedef struct packed {
        logic [5:0][4:0] din;
        logic [5:0][7:0] seg;
    } vec_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] din [6];
    logic [7:0] seg_out, seg_b;
    logic [5:0] sel_out, sel_b;

    int checks   = 0;
    int failures = 0;

    logic [6:0] dec_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [5:0] rel_sel [11] = '{6'h3F, 6'h3F, 6'h3E, 6'h3E, 6'h3E, 6'h3E, 6'h3E, 6'h3E,
                                 6'h3F, 6'h3F, 6'h3D};
    vec_t vecs [18];

    seven_seg_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]), .in4(din[4]), .in5(din[5]),
        .seg_out(seg_out), .sel_out(sel_out)
    );

    seven_seg_scan_driver #(.REFRESH_DIV(RD_B), .BLANK_CYCLES(BL_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]), .in4(din[4]), .in5(din[5]),
        .seg_out(seg_b), .sel_out(sel_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected {sel, seg} for the cycle after each edge.
    int         m_cnt = 0;
    int         m_idx = 0;
    logic [4:0] m_snap [6];
    logic [13:0] exp_q [$];
    logic [13:0] e;

    function automatic logic [13:0] ref_out(input int c, input int i, input logic [4:0] s);
        logic [5:0] sel;
        if (c < BL) return {6'h3F, 8'hFF};
        sel = ~(6'b00_0001 << i);
        return {sel, ~s[4], dec_tbl[s[3:0]]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0;
            m_idx <= 0;
            for (int k = 0; k < 6; k++) m_snap[k] <= 5'h00;
            exp_q.delete();
        end else begin
            exp_q.push_back(ref_out(m_cnt, m_idx, m_snap[m_idx]));
            if (m_idx == 0 && m_cnt == BL - 1)
                for (int k = 0; k < 6; k++) m_snap[k] <= din[k];
            if (m_cnt == RD - 1) begin
                m_cnt <= 0;
                m_idx <= (m_idx == 5) ? 0 : m_idx + 1;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_sel", 32'(sel_out), 32'h3F);
            check("reset_seg", 32'(seg_out), 32'hFF);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_sel", 32'(sel_out), 32'(e[13:8]));
            check("sb_seg", 32'(seg_out), 32'(e[7:0]));
        end
        check("onehot_a", 32'($countones(~sel_out) <= 1), 32'd1);
        check("onehot_b", 32'($countones(~sel_b) <= 1), 32'd1);
    end

    task automatic wait_frame_start();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_idx == 0 && m_cnt == 0) && n < 2 * FRAME);
    endtask

    task automatic wait_lit(input int k, input logic [7:0] exp_seg, input string name);
        logic [5:0] want;
        int n;
        want = ~(6'b00_0001 << k);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sel_out !== want && n < 2 * FRAME);
        if (sel_out !== want) check({name, "_timeout"}, 32'(sel_out), 32'(want));
        else check(name, 32'(seg_out), 32'(exp_seg));
    endtask

    task automatic wait_fall_b(output int n, output bit ok);
        logic prev;
        prev = sel_b[0];
        n = 0;
        ok = 1'b0;
        while (!ok && n < 3 * 6 * RD_B) begin
            @(negedge clk);
            n++;
            ok = prev && !sel_b[0];
            prev = sel_b[0];
        end
    endtask

    initial begin
        int  n, lit;
        bit  ok;
        logic [3:0] v;
        logic       dp;

        for (int k = 0; k < 6; k++) din[k] = 5'h00;

        vecs[0].din = {5'h05, 5'h04, 5'h03, 5'h02, 5'h01, 5'h00};
        vecs[0].seg = {8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
        vecs[1].din = {5'h00, 5'h00, 5'h10, 5'h00, 5'h15, 5'h00};
        vecs[1].seg = {8'hC0, 8'hC0, 8'h40, 8'hC0, 8'h12, 8'hC0};
        for (int h = 0; h < 16; h++) begin
            for (int k = 0; k < 6; k++) begin
                v  = 4'((h + k) % 16);
                dp = (k == h % 6);
                vecs[2 + h].din[k] = {dp, v};
                vecs[2 + h].seg[k] = {~dp, dec_tbl[v]};
            end
        end

        // Reset held, then released: blank, digit 0 lit, blank, digit 1.
        repeat (3) begin
            @(negedge clk);
            check("hold_sel", 32'(sel_out), 32'h3F);
            check("hold_seg", 32'(seg_out), 32'hFF);
        end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            check("release_sel", 32'(sel_out), 32'(rel_sel[i]));
        end

        // Vector tables: decode, decimal point, hex sweep on every digit.
        for (int i = 0; i < 18; i++) begin
            wait_frame_start();
            for (int k = 0; k < 6; k++) din[k] = vecs[i].din[k];
            for (int k = 0; k < 6; k++) wait_lit(k, vecs[i].seg[k], "vec_seg");
        end

        // Inputs change while digit 2 is lit; the rest of the frame keeps the old snapshot.
        wait_frame_start();
        din[0] = 5'h09; din[1] = 5'h19; din[2] = 5'h05;
        din[3] = 5'h10; din[4] = 5'h00; din[5] = 5'h00;
        wait_lit(0, 8'h90, "coh_old0");
        wait_lit(1, 8'h10, "coh_old1");
        wait_lit(2, 8'h92, "coh_old2");
        din[0] = 5'h00; din[1] = 5'h10; din[2] = 5'h00;
        din[3] = 5'h11; din[4] = 5'h00; din[5] = 5'h00;
        wait_lit(3, 8'h40, "coh_old3");
        wait_lit(4, 8'hC0, "coh_old4");
        wait_lit(5, 8'hC0, "coh_old5");
        wait_frame_start();
        wait_lit(0, 8'hC0, "coh_new0");
        wait_lit(1, 8'h40, "coh_new1");
        wait_lit(2, 8'hC0, "coh_new2");
        wait_lit(3, 8'h79, "coh_new3");
        wait_lit(4, 8'hC0, "coh_new4");
        wait_lit(5, 8'hC0, "coh_new5");

        // Asynchronous reset while digit 4 is lit.
        wait_lit(4, 8'hC0, "pre_reset4");
        #2 rst_n = 1'b0;
        #1;
        check("async_sel", 32'(sel_out), 32'h3F);
        check("async_seg", 32'(seg_out), 32'hFF);
        din[0] = 5'h0A;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sel_out === 6'h3F && n < 4 * RD);
        check("restart_sel", 32'(sel_out), 32'h3E);
        check("restart_seg", 32'(seg_out), 32'h88);

        // Slot timing on the larger instance: lit window and digit period.
        wait_fall_b(n, ok);
        check("b_first_fall", 32'(ok), 32'd1);
        for (int r = 0; r < 2; r++) begin
            lit = 0;
            do begin
                lit++;
                @(negedge clk);
            end while (!sel_b[0] && lit < 2 * RD_B);
            check("b_lit_window", 32'(lit), 32'(RD_B - BL_B));
            wait_fall_b(n, ok);
            check("b_fall_seen", 32'(ok), 32'd1);
            check("b_digit_period", 32'(lit + n), 32'(6 * RD_B));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
